// File: rtl/aes_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : aes_frame_tx
// Function : Serialises one AES request (block, key size, key, mode) into a
//            byte stream framed by a continuous write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module aes_frame_tx #(
    parameter logic [7:0] ENC_CODE = 8'h01,
    parameter logic [7:0] DEC_CODE = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] block,
    input  logic [255:0] key,
    input  logic [1:0]   key_len,
    input  logic         encrypt,
    output logic         we,
    output logic [7:0]   Indata,
    output logic         busy,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_KSIZE = 3'd3,
        S_KEY   = 3'd4,
        S_MODE  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] c_klen_illegal = 2'b11;
    localparam logic [4:0] c_data_last    = 5'd15;

    state_t       r_state;
    state_t       w_state_next;
    logic [4:0]   r_cnt;
    logic [4:0]   w_cnt_next;
    logic [127:0] r_block;
    logic [255:0] r_key;
    logic [1:0]   r_key_len;
    logic         r_encrypt;
    logic         r_we;
    logic [7:0]   r_indata;
    logic         r_busy;
    logic         r_done;
    logic         r_err;

    logic         w_accept;
    logic         w_reject;
    logic         w_we_next;
    logic [7:0]   w_indata_next;
    logic [7:0]   w_ksize;
    logic [4:0]   w_key_last;
    logic [127:0] w_block_sh;
    logic [255:0] w_key_sh;

    assign w_accept = (r_state == S_IDLE) && start && (key_len != c_klen_illegal);
    assign w_reject = (r_state == S_IDLE) && start && (key_len == c_klen_illegal);

    always_comb begin
        w_ksize    = 8'd32;
        w_key_last = 5'd31;
        case (r_key_len)
            2'b00: begin
                w_ksize    = 8'd16;
                w_key_last = 5'd15;
            end
            2'b01: begin
                w_ksize    = 8'd24;
                w_key_last = 5'd23;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_START;
            end
            S_START: begin
                w_state_next = S_DATA;
                w_cnt_next   = 5'd0;
            end
            S_DATA: begin
                if (r_cnt == c_data_last) begin
                    w_state_next = S_KSIZE;
                    w_cnt_next   = 5'd0;
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                end
            end
            S_KSIZE: begin
                w_state_next = S_KEY;
                w_cnt_next   = 5'd0;
            end
            S_KEY: begin
                if (r_cnt == w_key_last) begin
                    w_state_next = S_MODE;
                    w_cnt_next   = 5'd0;
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                end
            end
            S_MODE:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    assign w_block_sh = r_block << {w_cnt_next, 3'b000};
    assign w_key_sh   = r_key << {w_cnt_next, 3'b000};

    always_comb begin
        w_we_next     = 1'b0;
        w_indata_next = 8'h00;
        case (w_state_next)
            S_START: w_we_next = 1'b1;
            S_DATA: begin
                w_we_next     = 1'b1;
                w_indata_next = w_block_sh[127:120];
            end
            S_KSIZE: begin
                w_we_next     = 1'b1;
                w_indata_next = w_ksize;
            end
            S_KEY: begin
                w_we_next     = 1'b1;
                w_indata_next = w_key_sh[255:248];
            end
            S_MODE: begin
                w_we_next     = 1'b1;
                w_indata_next = r_encrypt ? ENC_CODE : DEC_CODE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_block   <= '0;
            r_key     <= '0;
            r_key_len <= 2'b00;
            r_encrypt <= 1'b0;
            r_we      <= 1'b0;
            r_indata  <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_block   <= block;
                r_key     <= key;
                r_key_len <= key_len;
                r_encrypt <= encrypt;
            end
            r_we     <= w_we_next;
            r_indata <= w_indata_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= (w_state_next == S_DONE);
            r_err    <= w_reject;
        end
    end

    assign we     = r_we;
    assign Indata = r_indata;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: doc/aes_frame_tx.md
AES_FRAME_TX -- requirements
Module: aes_frame_tx

Interface
REQ-001 Parameter ENC_CODE, default 8'h01: mode byte sent for an encryption request.
REQ-002 Parameter DEC_CODE, default 8'h00: mode byte sent for a decryption request.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 block  input  128  plaintext or ciphertext block; byte 0 = block[127:120].
REQ-007 key  input  256  key, left-aligned; byte 0 = key[255:248].
REQ-008 key_len  input  2  key length: 2'b00 = 16 bytes, 2'b01 = 24 bytes, 2'b10 = 32 bytes, 2'b11 = illegal.
REQ-009 encrypt  input  1  1 = encryption request, 0 = decryption request.
REQ-010 we  output  1  frame-active strobe to the byte-serial AES loader.
REQ-011 Indata  output  8  byte driven to the AES loader.
REQ-012 busy  output  1  high from the cycle after start is accepted until the DONE state is left.
REQ-013 done  output  1  one-cycle pulse after the last frame byte.
REQ-014 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 States SHALL be IDLE, START, DATA, KSIZE, KEY, MODE and DONE, encoded in a registered state variable.
REQ-016 In IDLE with start=1 and key_len != 2'b11: capture block, key, key_len and encrypt into internal registers, then go to START on the next cycle.
REQ-017 In IDLE with start=1 and key_len == 2'b11: stay in IDLE and pulse err high for exactly one cycle; no frame is sent.
REQ-018 The START state lasts 1 cycle: we=1, Indata=8'h00. This lets the receiver leave its idle state.
REQ-019 The DATA state lasts 16 cycles: we=1, Indata = captured block bytes 0..15, MSB byte first.
REQ-020 The KSIZE state lasts 1 cycle: we=1, Indata = K, where K is 8'd16, 8'd24 or 8'd32 per the captured key_len.
REQ-021 The KEY state lasts K cycles: we=1, Indata = captured key bytes 0..K-1, starting at key[255:248]; the unused low key bits are never sent.
REQ-022 The MODE state lasts 1 cycle: we=1, Indata = ENC_CODE if the captured encrypt=1, else DEC_CODE.
REQ-023 The DONE state lasts 1 cycle: we=0, Indata=8'h00, done=1; then go to IDLE.
REQ-024 we SHALL remain continuously high from START through MODE, with no gaps; the total we-high span is K+19 cycles.
REQ-025 A single 5-bit byte counter SHALL index DATA and KEY bytes; it is cleared on each state entry and never wraps within a state.
REQ-026 All outputs SHALL be registered, so no combinational path runs from the inputs to the outputs.
REQ-027 start while busy=1 is ignored, with no err. Changes to block, key, key_len or encrypt while busy do not affect the frame in flight.
REQ-028 start asserted during DONE is ignored. A start held high re-triggers in IDLE, so back-to-back frames are separated by exactly one we-low cycle (DONE) plus the capture cycle.
REQ-029 Outside START through MODE: we=0 and Indata=8'h00.

Reset
REQ-030 reset=1 at a clock edge forces state=IDLE, counter=0, we=0, Indata=8'h00, busy=0, done=0 and err=0; it also clears the captured registers.
REQ-031 reset asserted mid-frame aborts the frame on the next edge: we drops, no done pulse is issued, and any partial frame is discarded.
REQ-032 reset has priority over start in the same cycle.

Verification
REQ-033 Encrypt, 16-byte key. Stimulus: block=128'h00112233_44556677_8899aabb_ccddeeff, key[255:128]=128'h000102..0f, key_len=00, encrypt=1. Required response: we high 35 cycles carrying 00, 00,11,..,ff, 10, 00,01,..,0f, 01; done pulses in the following cycle.
REQ-034 Decrypt, 32-byte key. Stimulus: key_len=10, encrypt=0, key=256'h000102..1f. Required response: we high 51 cycles; KSIZE byte = 8'h20; key bytes 00..1f; last byte 8'h00.
REQ-035 24-byte key. Stimulus: key_len=01. Required response: KSIZE byte = 8'h18; exactly 24 key bytes, ending with key[71:64]; we span 43 cycles.
REQ-036 Illegal length. Stimulus: key_len=11 with start. Required response: err high 1 cycle, we stays 0, busy stays 0.
REQ-037 Abort and protection. Stimulus: reset asserted at DATA byte 5, then a new start. Required response: we=0 on the next edge, no done; the fresh frame begins with 8'h00. Also, toggling start and block mid-frame leaves Indata unchanged versus the golden sequence.
